// File: rtl/product_accumulator.sv
// Product accumulator: sums a group of 64-bit unsigned products, counts the terms and flags any
// carry out of bit 63. A group closes on in_last or when the term counter reaches its maximum;
// the result is then held until the consumer takes it.
// Optional build macro: ACC_SATURATE_EN -- clamp acc to all-ones on carry out instead of wrapping.
module product_accumulator #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [63:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [64:0]      sum_ext;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_full;

    assign in_ready     = (state_q != StHold);
    assign out_valid    = (state_q == StHold);
    assign out_sum      = acc_q;
    assign out_count    = cnt_q;
    assign out_overflow = ovf_q;

    assign accept  = in_valid && in_ready;
    assign sum_ext = {1'b0, acc_q} + {1'b0, in_product};

    // Count the accepted term would produce, and whether it hits the forced-close limit
    always_comb begin
        cnt_inc  = (state_q == StIdle) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        cnt_full = (cnt_inc == CntMax);
    end

    // Datapath next-state: load on the first term of a group, accumulate afterwards
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            cnt_d = cnt_inc;
            if (state_q == StIdle) begin
                acc_d = in_product;
                ovf_d = 1'b0;
            end else begin
                // Flag is sticky for the rest of the group
                ovf_d = ovf_q | sum_ext[64];
`ifdef ACC_SATURATE_EN
                // Once at all-ones any further add either carries again or adds zero,
                // so the clamp holds for the rest of the group without extra state
                acc_d = sum_ext[64] ? '1 : sum_ext[63:0];
`else
                acc_d = sum_ext[63:0];
`endif
            end
        end
    end

    // Control FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    state_d = (in_last || cnt_full) ? StHold : StAccum;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset discards any partial or pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: table of groups with a result scoreboard,
// plus hand-written hold, forced-close and reset sequences.
module tb_product_accumulator;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_overflow;
    logic [63:0] in_product, out_sum;
    logic [15:0] out_count;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_overflow;
    logic [63:0] b_in_product, b_out_sum;
    logic [3:0]  b_out_count;

    always #5 clk = ~clk;

    product_accumulator #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
        .out_overflow(out_overflow)
    );

    product_accumulator #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_product(b_in_product), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
        .out_overflow(b_out_overflow)
    );

    typedef struct {
        int              n;
        logic [3:0][63:0] t;
        int              gap;
        logic [63:0]     sum;
        logic [15:0]     cnt;
        logic            ovf;
    } grp_t;

    typedef struct {
        logic [63:0] sum;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    grp_t tbl[6];

    function automatic grp_t mk(input int n, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input logic [63:0] d, input int gap,
                                input logic [63:0] s, input logic [15:0] cn, input logic o);
        grp_t r;
        r.n = n; r.t[0] = a; r.t[1] = b; r.t[2] = c; r.t[3] = d;
        r.gap = gap; r.sum = s; r.cnt = cn; r.ovf = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [63:0] s, input logic [15:0] c, input logic o);
        exp_t e;
        e.sum = s; e.cnt = c; e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Hold a term on the bus until it is accepted, then drop valid and scramble the data
    task automatic drive_term(input logic [63:0] p, input logic last);
        int w = 0;
        in_valid = 1'b1; in_product = p; in_last = last;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1");
        end
        tick();
        in_valid = 1'b0; in_product = {$urandom, $urandom}; in_last = 1'b1;
    endtask

    // Scoreboard: compare each result on the cycle it is handed over
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum 0x%0h, expected no result", out_sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_sum", out_sum, e.sum);
                chk("sb_count", 64'(out_count), 64'(e.cnt));
                chk("sb_overflow", 64'(out_overflow), 64'(e.ovf));
            end
        end
    end

    initial begin
        tbl[0] = mk(3, 64'd5, 64'd7, 64'd9, 64'd0, 0, 64'd21, 16'd3, 1'b0);
        tbl[1] = mk(2, 64'd10, 64'd20, 64'd0, 64'd0, 3, 64'd30, 16'd2, 1'b0);
        tbl[2] = mk(2, ALL1, 64'd2, 64'd0, 64'd0, 0, SAT ? ALL1 : 64'd1, 16'd2, 1'b1);
        tbl[3] = mk(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd5, 64'd0, 0,
                    SAT ? ALL1 : 64'd5, 16'd3, 1'b1);
        tbl[4] = mk(4, 64'd1, 64'd2, 64'd3, 64'd4, 1, 64'd10, 16'd4, 1'b0);
        tbl[5] = mk(2, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'd0, 2,
                    ALL1, 16'd2, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_product = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_overflow", 64'(out_overflow), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Table of groups, back-to-back with out_ready held high
        for (int g = 0; g < 6; g++) begin
            for (int j = 0; j < tbl[g].n; j++) begin
                if (j == tbl[g].n - 1) begin
                    push_exp(tbl[g].sum, tbl[g].cnt, tbl[g].ovf);
                    drive_term(tbl[g].t[j], 1'b1);
                    chk("close_out_valid", 64'(out_valid), 64'd1);
                    chk("close_in_ready", 64'(in_ready), 64'd0);
                end else begin
                    drive_term(tbl[g].t[j], 1'b0);
                    for (int k = 0; k < tbl[g].gap; k++) begin
                        tick();
                        chk("gap_out_valid", 64'(out_valid), 64'd0);
                        chk("gap_running_count", 64'(out_count), 64'(j + 1));
                    end
                end
            end
        end

        // Single term held for 5 cycles with the consumer stalled; input traffic is ignored
        tick();
        out_ready = 1'b0;
        push_exp(64'h1234, 16'd1, 1'b0);
        drive_term(64'h1234, 1'b1);
        in_valid = 1'b1; in_product = 64'd999; in_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_sum", out_sum, 64'h1234);
            chk("hold_count", 64'(out_count), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hold_release_valid", 64'(out_valid), 64'd0);
        chk("hold_release_ready", 64'(in_ready), 64'd1);

        // CNT_W=4 instance: 15 non-last terms force a close; the 16th waits for the handshake
        b_in_valid = 1'b1; b_in_product = 64'd1; b_in_last = 1'b0;
        repeat (15) tick();
        chk("force_out_valid", 64'(b_out_valid), 64'd1);
        chk("force_sum", b_out_sum, 64'd15);
        chk("force_count", 64'(b_out_count), 64'd15);
        chk("force_in_ready", 64'(b_in_ready), 64'd0);
        tick();
        tick();
        chk("force_stall_count", 64'(b_out_count), 64'd15);
        b_out_ready = 1'b1;
        tick();
        chk("force_release_valid", 64'(b_out_valid), 64'd0);
        chk("force_release_ready", 64'(b_in_ready), 64'd1);
        tick();
        b_in_valid = 1'b0;
        chk("force_next_sum", b_out_sum, 64'd1);
        chk("force_next_count", 64'(b_out_count), 64'd1);
        chk("force_next_valid", 64'(b_out_valid), 64'd0);

        // Reset mid-group: partial result discarded, outputs clear without a clock edge
        drive_term(64'd11, 1'b0);
        drive_term(64'd12, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_sum", out_sum, 64'd0);
        chk("midrst_count", 64'(out_count), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        push_exp(64'd7, 16'd2, 1'b0);
        drive_term(64'd3, 1'b0);
        drive_term(64'd4, 1'b1);
        chk("postrst_valid", 64'(out_valid), 64'd1);

        repeat (4) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so a stuck run still reports
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
